// File: rtl/spike_rate_decoder_if.sv
// Handshake and result bundle between the spike-train source/consumer and spike_rate_decoder.
// The decoder takes the slave modport; the producer/consumer side takes master.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 6,
  parameter int IDX_W = 6
);
  logic             start;
  logic             spike_a;
  logic             spike_b;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;
  logic [IDX_W-1:0] first_a;
  logic [IDX_W-1:0] first_b;
  logic [1:0]       winner;

  modport master (
    output start, spike_a, spike_b, result_ready,
    input  busy, result_valid, count_a, count_b, first_a, first_b, winner
  );

  modport slave (
    input  start, spike_a, spike_b, result_ready,
    output busy, result_valid, count_a, count_b, first_a, first_b, winner
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes on two output channels over a fixed window, records each channel's
// first-spike index and registers a class decision, offered through valid/ready.
module spike_rate_decoder #(
  parameter int WINDOW = 40,
  parameter int CNT_W  = 6,
  parameter int IDX_W  = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  spike_rate_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [IDX_W-1:0] WIN_IDX  = IDX_W'(WINDOW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [CNT_W-1:0] cnt_upd [2];
  logic [IDX_W-1:0] first_q   [2];
  logic [IDX_W-1:0] first_d   [2];
  logic [IDX_W-1:0] first_upd [2];
  logic [1:0]       spike;

  assign spike = {bus.spike_b, bus.spike_a};

  // Per-channel update as it would apply on a COUNT edge; index 0 is A, 1 is B.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      assign cnt_upd[gi]   = (spike[gi] && (cnt_q[gi] != CNT_MAX)) ? cnt_q[gi] + 1'b1 : cnt_q[gi];
      assign first_upd[gi] = (spike[gi] && (first_q[gi] == WIN_IDX)) ? idx_q : first_q[gi];
    end
  endgenerate

  function automatic logic [1:0] decide(input logic [CNT_W-1:0] ca, input logic [CNT_W-1:0] cb,
                                        input logic [IDX_W-1:0] fa, input logic [IDX_W-1:0] fb);
    logic [1:0] w;
    w = 2'b00;
    if (ca > cb)       w = 2'b01;
    else if (cb > ca)  w = 2'b10;
    else if (ca == '0) w = 2'b00;
    else if (fa < fb)  w = 2'b01;
    else if (fb < fa)  w = 2'b10;
    return w;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    winner_d = winner_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]   = cnt_q[i];
      first_d[i] = first_q[i];
    end
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = COUNT;
          idx_d    = '0;
          winner_d = 2'b00;
          for (int i = 0; i < 2; i++) begin
            cnt_d[i]   = '0;
            first_d[i] = WIN_IDX;
          end
        end
      end
      COUNT: begin
        idx_d = idx_q + 1'b1;
        for (int i = 0; i < 2; i++) begin
          cnt_d[i]   = cnt_upd[i];
          first_d[i] = first_upd[i];
        end
        // Decision uses this edge's updated totals so the last sample counts.
        if (idx_q == LAST_IDX) begin
          state_d  = HOLD;
          winner_d = decide(cnt_upd[0], cnt_upd[1], first_upd[0], first_upd[1]);
        end
      end
      HOLD: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      winner_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= '0;
        first_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      winner_q <= winner_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]   <= cnt_d[i];
        first_q[i] <= first_d[i];
      end
    end
  end

  assign bus.busy         = (state_q == COUNT);
  assign bus.result_valid = (state_q == HOLD);
  assign bus.count_a      = cnt_q[0];
  assign bus.count_b      = cnt_q[1];
  assign bus.first_a      = first_q[0];
  assign bus.first_b      = first_q[1];
  assign bus.winner       = winner_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized and directed bench for spike_rate_decoder (WINDOW=8, CNT_W=3) against a
// window-level reference model computed from whole spike trains.
module tb_spike_rate_decoder;
  localparam int W     = 8;
  localparam int CNT_W = 3;
  localparam int IDX_W = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  spike_rate_decoder_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  spike_rate_decoder #(.WINDOW(W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: whole-window statistics straight from the decoding rules.
  typedef struct {
    int ca;
    int cb;
    int fa;
    int fb;
    int win;
  } result_t;

  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    result_t r;
    int      pa;
    int      pb;
    int      cmax;
    cmax = (1 << CNT_W) - 1;
    pa = 0; pb = 0; r.fa = W; r.fb = W;
    for (int k = 0; k < W; k++) begin
      if (a[k]) begin pa++; if (r.fa == W) r.fa = k; end
      if (b[k]) begin pb++; if (r.fb == W) r.fb = k; end
    end
    r.ca = (pa > cmax) ? cmax : pa;
    r.cb = (pb > cmax) ? cmax : pb;
    if (r.ca != r.cb)    r.win = (r.ca > r.cb) ? 1 : 2;
    else if (r.ca == 0)  r.win = 0;
    else if (r.fa == r.fb) r.win = 0;
    else                 r.win = (r.fa < r.fb) ? 1 : 2;
    return r;
  endfunction

  task automatic check_result(input string tag, input result_t e);
    check({tag, ".count_a"}, int'(bus.count_a), e.ca);
    check({tag, ".count_b"}, int'(bus.count_b), e.cb);
    check({tag, ".first_a"}, int'(bus.first_a), e.fa);
    check({tag, ".first_b"}, int'(bus.first_b), e.fb);
    check({tag, ".winner"},  int'(bus.winner),  e.win);
  endtask

  // One full decode: start, WINDOW samples, optional backpressure with start pokes, handshake.
  task automatic run_window(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int hold_cycles, input bit poke_start, output result_t got);
    result_t e;
    e = model(a, b);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ".busy_start"}, int'(bus.busy), 1);
    check({tag, ".clr_count_a"}, int'(bus.count_a), 0);
    check({tag, ".clr_first_b"}, int'(bus.first_b), W);
    for (int k = 0; k < W; k++) begin
      bus.spike_a = a[k];
      bus.spike_b = b[k];
      @(negedge clk);
      if (k < W - 1) check({tag, ".valid_early"}, int'(bus.result_valid), 0);
    end
    bus.spike_a = 1'b0;
    bus.spike_b = 1'b0;
    check({tag, ".valid"}, int'(bus.result_valid), 1);
    check({tag, ".busy_end"}, int'(bus.busy), 0);
    check_result(tag, e);
    for (int h = 0; h < hold_cycles; h++) begin
      bus.start   = poke_start ? 1'b1 : 1'b0;
      bus.spike_a = 1'($urandom);
      bus.spike_b = 1'($urandom);
      @(negedge clk);
      check({tag, ".hold_valid"}, int'(bus.result_valid), 1);
      check({tag, ".hold_busy"}, int'(bus.busy), 0);
      check_result({tag, ".hold"}, e);
    end
    bus.start        = 1'b1;
    bus.spike_a      = 1'b0;
    bus.spike_b      = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    check({tag, ".ack_valid"}, int'(bus.result_valid), 0);
    check({tag, ".ack_busy"}, int'(bus.busy), 0);
    check_result({tag, ".kept"}, e);
    got.ca  = int'(bus.count_a);
    got.cb  = int'(bus.count_b);
    got.fa  = int'(bus.first_a);
    got.fb  = int'(bus.first_b);
    got.win = int'(bus.winner);
    $display("window %s a=%b b=%b -> ca=%0d cb=%0d fa=%0d fb=%0d win=%0d",
             tag, a, b, got.ca, got.cb, got.fa, got.fb, got.win);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"},    int'(bus.busy), 0);
    check({tag, ".valid"},   int'(bus.result_valid), 0);
    check({tag, ".count_a"}, int'(bus.count_a), 0);
    check({tag, ".count_b"}, int'(bus.count_b), 0);
    check({tag, ".first_a"}, int'(bus.first_a), 0);
    check({tag, ".first_b"}, int'(bus.first_b), 0);
    check({tag, ".winner"},  int'(bus.winner), 0);
  endtask

  initial begin
    result_t r1;
    result_t r2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks   = 0;
    failures = 0;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.spike_a      = 1'b0;
    bus.spike_b      = 1'b0;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start", int'(bus.busy), 0);

    // Abort mid-window with spikes active.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.spike_a = 1'b1;
    bus.spike_b = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.spike_a = 1'b0;
    bus.spike_b = 1'b0;
    check("abort_idle_busy", int'(bus.busy), 0);
    check("abort_idle_valid", int'(bus.result_valid), 0);

    run_window("a_win",    8'b01010101, 8'b10001000, 0, 1'b0, r1);
    run_window("tie_time", 8'b00100100, 8'b01000010, 0, 1'b0, r1);
    run_window("silence",  8'b00000000, 8'b00000000, 0, 1'b0, r1);
    run_window("saturate", 8'b11111111, 8'b00000000, 0, 1'b0, r1);
    run_window("backpress", 8'b00110010, 8'b01101100, 5, 1'b1, r1);

    for (int t = 0; t < 20; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_window($sformatf("rand%0d", t), ra, rb, $urandom_range(0, 3), 1'($urandom), r1);
    end

    ra = W'($urandom);
    rb = W'($urandom);
    run_window("b2b_first", ra, rb, 0, 1'b0, r1);
    run_window("b2b_second", ra, rb, 0, 1'b0, r2);
    check("b2b.count_a", r2.ca, r1.ca);
    check("b2b.count_b", r2.cb, r1.cb);
    check("b2b.winner", r2.win, r1.win);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
